rr_mux_arbiter: RTL and testbench



---
 rtl/muxarb_pkg.sv | 41 ++++
 rtl/sel_mux.sv | 13 +
 rtl/rr_mux_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muxarb_pkg.sv
// Shared types and the round-robin winner search for rr_mux_arbiter.
package muxarb_pkg;

  // The search is written once for the widest legal requester count.
  localparam int MAX_N = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n (not at MAX_N).
  function automatic pick_t rr_pick(
    input logic [MAX_N-1:0] req,
    input logic [IDX_W-1:0] ptr,
    input int               n
  );
    pick_t r;
    int    j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!r.found && req[j[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_mux.sv
// Parameterised N:1 single-bit combinational select mux.
module sel_mux #(
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     d,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = d[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared N:1 mux select with bounded bursts.
// Optional MUXARB_LOCK_EN adds a lock input that extends a burst past BURST_LEN.
module rr_mux_arbiter
  import muxarb_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int BURST_LEN = 4,
  localparam int SEL_W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUXARB_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     d,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             y_valid,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  state_t           state, state_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] pick_sel;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_sel;
  logic             hold;
  logic             mux_y;
  pick_t            pick;

  // Explicit wrap so a non-power-of-2 N goes N-1 -> 0, never to N.
  assign sel_inc = (sel == SEL_LAST) ? '0 : sel + 1'b1;
  assign req_sel = req[sel];

`ifdef MUXARB_LOCK_EN
  assign hold = req_sel && ((cnt < CNT_MAX) || lock);
`else
  assign hold = req_sel && (cnt < CNT_MAX);
`endif

  // On release the holder is scanned last, so a lone requester is re-granted.
  assign base     = (state == GRANT) ? sel_inc : ptr;
  assign pick     = rr_pick(MAX_N'(req), IDX_W'(base), N);
  assign pick_sel = SEL_W'(pick.idx);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (pick.found) begin
          state_nxt         = GRANT;
          gnt_nxt           = '0;
          gnt_nxt[pick_sel] = 1'b1;
          sel_nxt           = pick_sel;
          cnt_nxt           = CNT_ONE;
        end
      end
      GRANT: begin
        if (hold) begin
          // Saturates at BURST_LEN while a lock stretches the burst.
          if (cnt < CNT_MAX) cnt_nxt = cnt + CNT_ONE;
        end else begin
          ptr_nxt = sel_inc;
          if (pick.found) begin
            gnt_nxt           = '0;
            gnt_nxt[pick_sel] = 1'b1;
            sel_nxt           = pick_sel;
            cnt_nxt           = CNT_ONE;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sel_mux #(.N(N)) u_sel_mux (
    .d   (d),
    .sel (sel),
    .y   (mux_y)
  );

  // Output logic
  always_comb begin
    busy    = (state == GRANT);
    y_valid = busy & req_sel;
    y       = y_valid ? mux_y : 1'b0;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: expectations queued at drive time, popped at sample time.
module tb_rr_mux_arbiter;

  localparam int N         = 8;
  localparam int BURST_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] d;
`ifdef MUXARB_LOCK_EN
  logic       lock;
`endif
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       y_valid;
  logic       busy;

  rr_mux_arbiter #(.N(N), .BURST_LEN(BURST_LEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef MUXARB_LOCK_EN
    .lock    (lock),
`endif
    .req     (req),
    .d       (d),
    .gnt     (gnt),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       y_valid;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] g, input logic [2:0] s,
                      input logic yy, input logic yv, input logic b);
    sb.push_back('{tag: tag, gnt: g, sel: s, y: yy, y_valid: yv, busy: b});
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_underflow observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".gnt"},     gnt,            e.gnt);
    check({e.tag, ".sel"},     8'(sel),        8'(e.sel));
    check({e.tag, ".y"},       8'(y),          8'(e.y));
    check({e.tag, ".y_valid"}, 8'(y_valid),    8'(e.y_valid));
    check({e.tag, ".busy"},    8'(busy),       8'(e.busy));
  endtask

  // Expectation for the state after the next rising edge.
  task automatic cycle_exp(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic yy, input logic yv, input logic b);
    push(tag, g, s, yy, yv, b);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Expectation for the current state, without a clock edge.
  task automatic now_exp(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic yy, input logic yv, input logic b);
    push(tag, g, s, yy, yv, b);
    #1;
    pop_check();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    req   = 8'hFF;
    d     = 8'hFF;
`ifdef MUXARB_LOCK_EN
    lock  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    now_exp("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Lone requester 5: continuous grant, re-granted after the burst with no gap.
    req   = 8'h20;
    d     = 8'h20;
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle_exp($sformatf("single_e%0d", e), 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
      if (e == 5) req = 8'h21;
    end
    // Second burst started at edge 5, so it expires at edge 9; search starts at 6.
    cycle_exp("single_handoff", 8'h01, 3'd0, 1'b0, 1'b1, 1'b1);
    req = 8'h00;
    now_exp("drop_valid", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
    cycle_exp("to_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Full contention: 0..7 then 0 again, each held BURST_LEN cycles.
    reset_pulse();
    req = 8'hFF;
    d   = 8'hA6;
    for (int e = 1; e <= 33; e++) begin
      k = ((e - 1) / BURST_LEN) % N;
      cycle_exp($sformatf("contend_e%0d", e), 8'(1 << k), 3'(k), d[k], 1'b1, 1'b1);
    end

    // Async reset between edges while requester 3 holds the mux.
    reset_pulse();
    for (int e = 1; e <= 14; e++) begin
      k = ((e - 1) / BURST_LEN) % N;
      cycle_exp($sformatf("preburst_e%0d", e), 8'(1 << k), 3'(k), d[k], 1'b1, 1'b1);
    end
    #3;
    rst_n = 1'b0;
    now_exp("async_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // First arbitration after reset scans from 0; then early release of 2.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'h44;
    d     = 8'h40;
    cycle_exp("ptr_cleared", 8'h04, 3'd2, 1'b0, 1'b1, 1'b1);
    cycle_exp("early_e2",    8'h04, 3'd2, 1'b0, 1'b1, 1'b1);
    req = 8'h40;
    now_exp("early_drop", 8'h04, 3'd2, 1'b0, 1'b0, 1'b1);
    cycle_exp("early_handoff", 8'h40, 3'd6, 1'b1, 1'b1, 1'b1);

    // Requesters 3 and 4: burst limit with and without lock.
    reset_pulse();
    req = 8'h18;
    d   = 8'h08;
`ifdef MUXARB_LOCK_EN
    lock = 1'b1;
    for (int e = 1; e <= 10; e++)
      cycle_exp($sformatf("lock_e%0d", e), 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
    lock = 1'b0;
    cycle_exp("lock_release", 8'h10, 3'd4, 1'b0, 1'b1, 1'b1);
`else
    for (int e = 1; e <= BURST_LEN; e++)
      cycle_exp($sformatf("limit_e%0d", e), 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
    cycle_exp("limit_release", 8'h10, 3'd4, 1'b0, 1'b1, 1'b1);
`endif

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
